fc_receive_ctrl: RTL and testbench
==================================

// Module: fc_receive_ctrl
// PURPOSE
//  Receive engine for the FC accelerator, downstream of the FC APB register block.
//  Consumes receiveCommand/receive_size and accepts a 32-bit AXI-Stream.
//  Writes each beat into the feature, bias or weight buffer.
//  Returns feature/bias/weight_receive_done to the register block for CPU polling.
// PARAMETERS
//  DATA_W  32  stream and buffer write data width
//  ADDR_W  16  buffer write address width; address wraps modulo 2^ADDR_W
//  SIZE_W  21  width of receive_size (words)
// PORTS
//  PCLK                  in   1       clock
//  PRESETB               in   1       asynchronous active-low reset
//  receiveCommand        in   3       0=idle/clear, 1=feature, 2=bias, 3=weight, 4-7 ignored
//  receive_size          in   SIZE_W  words to receive; sampled at start
//  s_axis_tdata          in   DATA_W  stream data
//  s_axis_tvalid         in   1       stream valid
//  s_axis_tlast          in   1       stream last (checked, not used for counting)
//  s_axis_tready         out  1       stream ready
//  buf_wr_en             out  1       buffer write strobe
//  buf_wr_sel            out  2       1=feature, 2=bias, 3=weight
//  buf_wr_addr           out  ADDR_W  word address, starts at 0 per transfer
//  buf_wr_data           out  DATA_W  write data
//  feature_receive_done  out  1       sticky done, feature transfer
//  bias_receive_done     out  1       sticky done, bias transfer
//  weight_receive_done   out  1       sticky done, weight transfer
//  tlast_error           out  1       sticky: TLAST position did not match receive_size
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; cmd_q = 0; counters = 0.
//  cmd_q registers receiveCommand every cycle.
//  Start condition: cmd_q==0 and receiveCommand in {1,2,3}.
//  FSM IDLE -> RECV on start; latch sel = command and size = receive_size; count = 0.
//    If the latched size==0, go straight to DONE.
//  RECV: s_axis_tready = 1, and only in this state.
//    A beat is s_axis_tvalid & s_axis_tready.
//    On a beat, the cycle after it: buf_wr_en=1, addr=count[ADDR_W-1:0], data=tdata, sel=sel.
//    The beat also increments count.
//    Beat with count==size-1 (final beat): -> DONE next cycle; tready drops that cycle.
//  TLAST check:
//    final beat without tlast -> tlast_error=1.
//    tlast on a non-final beat -> tlast_error=1; counting continues.
//  DONE: the done flag for sel rises on the first DONE cycle.
//    That is one cycle after the last buf_wr_en pulse (two cycles after the final beat).
//    The flag stays high while receiveCommand != 0.
//  Any state, receiveCommand==0:
//    state -> IDLE next cycle; all three done flags and tlast_error cleared.
//    In RECV this aborts the transfer: no done, nothing after the last accepted beat is written.
//    A beat registered in the abort cycle is still written.
//  Command changes nonzero -> different nonzero in RECV or DONE: ignored. CPU must write 0 first.
//  Command 4-7 from idle: no start, tready stays 0.
//  Address wraps to 0 after 2^ADDR_W-1; count itself is SIZE_W wide.
//  Reset mid-transfer: immediate return to reset values; partial data is abandoned.
// TESTING
//  1. Feature, size=4, tvalid continuous, tlast on beat 4 ->
//     4 wr_en pulses, addr 0..3, sel=1.
//     feature_receive_done high 2 cycles after beat 4; tlast_error=0.
//  2. Weight, size=3, tvalid toggling 1/0 ->
//     3 writes with correct data order; weight_receive_done=1; bias/feature done=0.
//  3. Bias, size=0 -> bias_receive_done=1 two cycles after the command; tready never high; no writes.
//  4. Feature, size=5, tlast on beat 2 ->
//     5 writes; tlast_error=1; feature_receive_done=1.
//     Then write command 0 -> both flags clear next cycle.
//  5. Weight, size=8, command->0 after 3 beats ->
//     exactly 3 writes; no done; IDLE.
//     Then command 2, size 2 completes normally.
//  6. PRESETB low during a feature receive after 2 beats ->
//     all outputs 0 immediately; after release, no writes until a fresh 0->nonzero command.

Source files
------------

// File: rtl/fc_receive_ctrl.sv
// FC accelerator receive engine: takes a 32-bit AXI-Stream and writes each beat into the
// feature, bias or weight buffer, raising a sticky done flag per buffer for the CPU to poll.
module fc_receive_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int SIZE_W = 21
) (
    input  logic              PCLK,
    input  logic              PRESETB,
    input  logic [2:0]        receiveCommand,
    input  logic [SIZE_W-1:0] receive_size,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic              buf_wr_en,
    output logic [1:0]        buf_wr_sel,
    output logic [ADDR_W-1:0] buf_wr_addr,
    output logic [DATA_W-1:0] buf_wr_data,
    output logic              feature_receive_done,
    output logic              bias_receive_done,
    output logic              weight_receive_done,
    output logic              tlast_error
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RECV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [2:0]        cmd_q;
    logic [1:0]        sel_q;
    logic [SIZE_W-1:0] size_q;
    logic [SIZE_W-1:0] count;
    logic [SIZE_W-1:0] size_m1;
    logic              beat;
    logic              final_beat;
    logic              start;
    logic              clr;

    assign s_axis_tready = (state == S_RECV);
    assign beat          = s_axis_tvalid & s_axis_tready;
    assign size_m1       = size_q - SIZE_W'(1);
    assign final_beat    = (count == size_m1);
    // Only a 0 -> {1,2,3} edge starts a transfer; 4-7 have bit 2 set and are ignored.
    assign start         = (cmd_q == 3'd0) && (receiveCommand != 3'd0) && !receiveCommand[2];
    assign clr           = (receiveCommand == 3'd0);

    always_ff @(posedge PCLK or negedge PRESETB) begin
        if (!PRESETB) begin
            state                <= S_IDLE;
            cmd_q                <= 3'd0;
            sel_q                <= 2'd0;
            size_q               <= '0;
            count                <= '0;
            buf_wr_en            <= 1'b0;
            buf_wr_sel           <= 2'd0;
            buf_wr_addr          <= '0;
            buf_wr_data          <= '0;
            feature_receive_done <= 1'b0;
            bias_receive_done    <= 1'b0;
            weight_receive_done  <= 1'b0;
            tlast_error          <= 1'b0;
        end else begin
            cmd_q     <= receiveCommand;
            // A beat accepted in an abort cycle is still written out.
            buf_wr_en <= beat;
            if (beat) begin
                buf_wr_sel  <= sel_q;
                buf_wr_addr <= count[ADDR_W-1:0];
                buf_wr_data <= s_axis_tdata;
            end

            if (clr) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: if (start) begin
                        sel_q  <= receiveCommand[1:0];
                        size_q <= receive_size;
                        count  <= '0;
                        state  <= (receive_size == '0) ? S_DONE : S_RECV;
                    end
                    S_RECV: if (beat) begin
                        count <= count + SIZE_W'(1);
                        if (final_beat) state <= S_DONE;
                    end
                    default: ;
                endcase
            end

            if (clr) begin
                tlast_error <= 1'b0;
            end else if (beat && (final_beat != s_axis_tlast)) begin
                tlast_error <= 1'b1;
            end

            if (clr) begin
                feature_receive_done <= 1'b0;
                bias_receive_done    <= 1'b0;
                weight_receive_done  <= 1'b0;
            end else if (state == S_DONE) begin
                case (sel_q)
                    2'd1:    feature_receive_done <= 1'b1;
                    2'd2:    bias_receive_done    <= 1'b1;
                    2'd3:    weight_receive_done  <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fc_receive_ctrl.sv
// Self-checking bench for fc_receive_ctrl: randomized streams compared against a
// transfer-level model (expected write list and flag vector per transfer).
module tb_fc_receive_ctrl;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;
    localparam int SIZE_W = 21;

    logic              PCLK = 1'b0;
    logic              PRESETB = 1'b0;
    logic [2:0]        receiveCommand = 3'd0;
    logic [SIZE_W-1:0] receive_size = '0;
    logic [DATA_W-1:0] s_axis_tdata = '0;
    logic              s_axis_tvalid = 1'b0;
    logic              s_axis_tlast = 1'b0;
    logic              s_axis_tready;
    logic              buf_wr_en;
    logic [1:0]        buf_wr_sel;
    logic [ADDR_W-1:0] buf_wr_addr;
    logic [DATA_W-1:0] buf_wr_data;
    logic              feature_receive_done;
    logic              bias_receive_done;
    logic              weight_receive_done;
    logic              tlast_error;

    fc_receive_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SIZE_W(SIZE_W)) dut (
        .PCLK(PCLK), .PRESETB(PRESETB),
        .receiveCommand(receiveCommand), .receive_size(receive_size),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .buf_wr_en(buf_wr_en), .buf_wr_sel(buf_wr_sel),
        .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
        .feature_receive_done(feature_receive_done),
        .bias_receive_done(bias_receive_done),
        .weight_receive_done(weight_receive_done),
        .tlast_error(tlast_error)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]        sel;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t               wr_q[$];
    logic [DATA_W-1:0] src[$];
    logic [3:0]        flags;

    assign flags = {tlast_error, weight_receive_done, bias_receive_done, feature_receive_done};

    always @(negedge PCLK) begin
        if (buf_wr_en === 1'b1) begin
            wr_t w;
            w.sel  = buf_wr_sel;
            w.addr = buf_wr_addr;
            w.data = buf_wr_data;
            wr_q.push_back(w);
        end
    end

    // Compare captured writes with the first n source words in order.
    task automatic check_writes(input string name, input logic [1:0] sel, input int n);
        checks++;
        if (wr_q.size() !== n) begin
            errors++;
            $display("FAIL %s write count: got %0d expected %0d", name, wr_q.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                checks++;
                if (wr_q[i].sel !== sel || wr_q[i].addr !== ADDR_W'(i) || wr_q[i].data !== src[i]) begin
                    errors++;
                    $display("FAIL %s write %0d: got sel=%0d addr=%0h data=%h expected sel=%0d addr=%0h data=%h",
                             name, i, wr_q[i].sel, wr_q[i].addr, wr_q[i].data, sel, ADDR_W'(i), src[i]);
                end
            end
        end
    endtask

    // mode: 0 continuous tvalid, 1 toggling, 2 random. tlast_pos is the 1-based beat carrying tlast (0 = none).
    task automatic xfer(input string name, input logic [2:0] cmd, input int size, input int tlast_pos, input int mode);
        int         idx = 0;
        int         cyc = 0;
        logic       beat;
        logic [3:0] exp_flags;
        wr_q.delete();
        src.delete();
        for (int i = 0; i < size; i++) src.push_back($urandom);
        exp_flags = {(size != 0) && (tlast_pos != size), cmd == 3'd3, cmd == 3'd2, cmd == 3'd1};
        @(posedge PCLK); #1;
        receiveCommand = cmd;
        receive_size   = SIZE_W'(size);
        if (size == 0) begin
            for (int k = 0; k < 2; k++) begin
                @(negedge PCLK);
                checks++;
                if (flags !== 4'b0 || s_axis_tready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s early cycle %0d: got flags=%b tready=%b expected flags=0000 tready=0",
                             name, k, flags, s_axis_tready);
                end
            end
            @(negedge PCLK);
            checks++;
            if (flags !== exp_flags || s_axis_tready !== 1'b0) begin
                errors++;
                $display("FAIL %s done: got flags=%b tready=%b expected flags=%b tready=0",
                         name, flags, s_axis_tready, exp_flags);
            end
        end else begin
            while (idx < size && cyc < 200) begin
                s_axis_tvalid = (mode == 0) ? 1'b1 : (mode == 1) ? ~cyc[0] : 1'($urandom_range(0, 1));
                s_axis_tdata  = src[idx];
                s_axis_tlast  = (idx + 1 == tlast_pos);
                @(negedge PCLK);
                beat = s_axis_tvalid && s_axis_tready;
                @(posedge PCLK); #1;
                if (beat) idx++;
                cyc++;
            end
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
            checks++;
            if (idx != size) begin
                errors++;
                $display("FAIL %s timeout: got %0d beats expected %0d", name, idx, size);
            end
            @(negedge PCLK);
            checks++;
            if (buf_wr_en !== 1'b1 || flags[2:0] !== 3'b0 || s_axis_tready !== 1'b0) begin
                errors++;
                $display("FAIL %s after final beat: got wr_en=%b done=%b tready=%b expected 1 000 0",
                         name, buf_wr_en, flags[2:0], s_axis_tready);
            end
            @(negedge PCLK);
            checks++;
            if (flags !== exp_flags || s_axis_tready !== 1'b0) begin
                errors++;
                $display("FAIL %s done: got flags=%b tready=%b expected flags=%b tready=0",
                         name, flags, s_axis_tready, exp_flags);
            end
        end
        check_writes(name, cmd[1:0], size);
    endtask

    task automatic release_cmd(input string name);
        @(posedge PCLK); #1;
        receiveCommand = 3'd0;
        @(negedge PCLK);
        @(negedge PCLK);
        checks++;
        if (flags !== 4'b0 || s_axis_tready !== 1'b0) begin
            errors++;
            $display("FAIL %s clear: got flags=%b tready=%b expected 0000 0", name, flags, s_axis_tready);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({s_axis_tready, buf_wr_en, buf_wr_sel, buf_wr_addr, buf_wr_data, flags} !== '0) begin
            errors++;
            $display("FAIL reset: got tready=%b wr_en=%b sel=%0d addr=%0h data=%h flags=%b expected all 0",
                     s_axis_tready, buf_wr_en, buf_wr_sel, buf_wr_addr, buf_wr_data, flags);
        end
        repeat (2) @(posedge PCLK);
        #1 PRESETB = 1'b1;
    endtask

    task automatic test_feature_basic();
        xfer("feature4", 3'd1, 4, 4, 0);
        release_cmd("feature4");
    endtask

    task automatic test_weight_toggle();
        xfer("weight3", 3'd3, 3, 3, 1);
        release_cmd("weight3");
    endtask

    task automatic test_bias_zero();
        xfer("bias0", 3'd2, 0, 0, 0);
        release_cmd("bias0");
    endtask

    task automatic test_tlast_error();
        xfer("tlast_early", 3'd1, 5, 2, 0);
        release_cmd("tlast_early");
        xfer("tlast_missing", 3'd3, 4, 0, 2);
        release_cmd("tlast_missing");
    endtask

    task automatic test_illegal_cmd();
        for (int c = 4; c < 8; c++) begin
            wr_q.delete();
            @(posedge PCLK); #1;
            receiveCommand = 3'(c);
            receive_size   = SIZE_W'(3);
            s_axis_tvalid  = 1'b1;
            repeat (4) @(negedge PCLK);
            checks++;
            if (s_axis_tready !== 1'b0 || flags !== 4'b0 || wr_q.size() != 0) begin
                errors++;
                $display("FAIL illegal_cmd %0d: got tready=%b flags=%b writes=%0d expected 0 0000 0",
                         c, s_axis_tready, flags, wr_q.size());
            end
            s_axis_tvalid = 1'b0;
            release_cmd("illegal_cmd");
        end
    endtask

    // Abort after n beats; optionally present one more beat in the abort cycle itself.
    task automatic test_abort(input string name, input int n, input bit beat_in_abort);
        int idx = 0;
        int cyc = 0;
        logic beat;
        wr_q.delete();
        src.delete();
        for (int i = 0; i < 8; i++) src.push_back($urandom);
        @(posedge PCLK); #1;
        receiveCommand = 3'd3;
        receive_size   = SIZE_W'(8);
        while (idx < n && cyc < 100) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = src[idx];
            @(negedge PCLK);
            beat = s_axis_tvalid && s_axis_tready;
            @(posedge PCLK); #1;
            if (beat) idx++;
            cyc++;
        end
        receiveCommand = 3'd0;
        s_axis_tvalid  = beat_in_abort;
        s_axis_tdata   = src[idx];
        @(negedge PCLK);
        checks++;
        if (s_axis_tready !== 1'b1) begin
            errors++;
            $display("FAIL %s abort cycle tready: got %b expected 1", name, s_axis_tready);
        end
        @(posedge PCLK); #1;
        for (int k = 0; k < 4; k++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = $urandom;
            @(negedge PCLK);
            checks++;
            if (s_axis_tready !== 1'b0 || flags !== 4'b0) begin
                errors++;
                $display("FAIL %s after abort: got tready=%b flags=%b expected 0 0000", name, s_axis_tready, flags);
            end
            @(posedge PCLK); #1;
        end
        s_axis_tvalid = 1'b0;
        check_writes(name, 2'd3, n + int'(beat_in_abort));
        xfer({name, "_next"}, 3'd2, 2, 2, 0);
        release_cmd(name);
    endtask

    task automatic test_reset_mid();
        int idx = 0;
        int cyc = 0;
        logic beat;
        src.delete();
        for (int i = 0; i < 6; i++) src.push_back($urandom);
        @(posedge PCLK); #1;
        receiveCommand = 3'd1;
        receive_size   = SIZE_W'(6);
        while (idx < 2 && cyc < 100) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = src[idx];
            @(negedge PCLK);
            beat = s_axis_tvalid && s_axis_tready;
            @(posedge PCLK); #1;
            if (beat) idx++;
            cyc++;
        end
        PRESETB        = 1'b0;
        receiveCommand = 3'd0;
        #1;
        checks++;
        if ({s_axis_tready, buf_wr_en, buf_wr_sel, buf_wr_addr, buf_wr_data, flags} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got tready=%b wr_en=%b sel=%0d addr=%0h data=%h flags=%b expected all 0",
                     s_axis_tready, buf_wr_en, buf_wr_sel, buf_wr_addr, buf_wr_data, flags);
        end
        repeat (2) @(posedge PCLK);
        #1 PRESETB = 1'b1;
        wr_q.delete();
        for (int k = 0; k < 4; k++) begin
            @(negedge PCLK);
            checks++;
            if (s_axis_tready !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid idle tready: got %b expected 0", s_axis_tready);
            end
        end
        s_axis_tvalid = 1'b0;
        checks++;
        if (wr_q.size() != 0) begin
            errors++;
            $display("FAIL reset_mid stray writes: got %0d expected 0", wr_q.size());
        end
        xfer("reset_mid_fresh", 3'd1, 3, 3, 2);
        release_cmd("reset_mid_fresh");
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            int cmd  = $urandom_range(1, 3);
            int size = $urandom_range(1, 12);
            int tpos = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, size + 1)) : size;
            xfer("random", 3'(cmd), size, tpos, 2);
            release_cmd("random");
        end
    endtask

    initial begin
        test_reset();
        test_feature_basic();
        test_weight_toggle();
        test_bias_zero();
        test_tlast_error();
        test_illegal_cmd();
        test_abort("abort3", 3, 1'b0);
        test_abort("abort_beat", 2, 1'b1);
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
